noc_switch_arbiter: RTL

Output-port arbiter and flow controller for one NOC switch stage. It takes head flits from RADIX_IN input FIFOs and decodes each flit's route field for this stage. For each of the RADIX_OUT output ports it grants one requester per cycle, round-robin, and forwards the flit through a registered output stage. Downstream FIFOs are protected by per-output credit counters, so the block never enqueues into a full FIFO, including across the one-cycle output register.

---
 rtl/noc_arb_pkg.sv | 30 +++
 rtl/noc_arb_credit_chk.sv | 19 +
 rtl/noc_rr_arb.sv | 51 +++++
 rtl/noc_switch_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
// Shared types, default widths and route decode for the NOC switch-stage arbiter.
// Flit width defaults to `ADDR_WIDTH + `DATA_WIDTH; both macros get fallbacks here.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 24
`endif

package noc_arb_pkg;

  localparam int NOC_FLIT_W     = `ADDR_WIDTH + `DATA_WIDTH;
  localparam int NOC_RADIX_OUT  = 2;
  localparam int NOC_SEL_W      = (NOC_RADIX_OUT > 1) ? $clog2(NOC_RADIX_OUT) : 1;
  localparam int NOC_DEST_MSB   = NOC_FLIT_W - 4;
  localparam int NOC_DOWN_DEPTH = 4;
  localparam int NOC_CREDIT_W   = $clog2(NOC_DOWN_DEPTH + 1);

  typedef logic [NOC_FLIT_W-1:0]   flit_t;
  typedef logic [NOC_SEL_W-1:0]    sel_t;
  typedef logic [NOC_CREDIT_W-1:0] credit_t;

  // Route field of a flit for a given stage, using the default geometry.
  function automatic sel_t route_of(input flit_t flit, input int unsigned stage);
    flit_t shifted;
    shifted = flit >> (NOC_DEST_MSB - int'(stage) * NOC_SEL_W - NOC_SEL_W + 1);
    return shifted[NOC_SEL_W-1:0];
  endfunction

endpackage

// File: rtl/noc_arb_credit_chk.sv
// Simulation check: a credit return must never arrive on a full credit counter.
module noc_arb_credit_chk #(
  parameter int R = 2
) (
  input logic         clk,
  input logic         rst,
  input logic [R-1:0] credit_ret,
  input logic [R-1:0] credit_full
);

  // Flag returns that the counter has to drop because it is saturated.
  always @(posedge clk) begin
    for (int o = 0; o < R; o++) begin
      assert (rst || !(credit_ret[o] && credit_full[o]))
        else $error("noc_switch_arbiter: credit return on full counter, output %0d", o);
    end
  end

endmodule

// File: rtl/noc_rr_arb.sv
// Round-robin arbiter over N requesters with its own pointer register.
// The pointer moves just past the winner whenever a grant is committed.
module noc_rr_arb
  import noc_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         update,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] next_ptr_s;
  logic             found_s;

  // First requester at or after ptr_r (wrapping) wins while enabled.
  always_comb begin
    int  idx;
    logic hit;
    grant      = '0;
    next_ptr_s = ptr_r;
    found_s    = 1'b0;
    idx        = 0;
    hit        = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx        = (int'(ptr_r) + k >= N) ? int'(ptr_r) + k - N : int'(ptr_r) + k;
      hit        = en && !found_s && req[idx];
      grant[idx] = hit;
      next_ptr_s = hit ? ((idx == N - 1) ? '0 : PTR_W'(idx + 1)) : next_ptr_s;
      found_s    = found_s | hit;
    end
  end

  // Pointer register; holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (update && found_s) begin
      ptr_r <= next_ptr_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/noc_switch_arbiter.sv
// Output-port arbiter and credit flow control for one NOC switch stage.
// Optional statistics counters are enabled with `define NOC_ARB_STATS_EN.
module noc_switch_arbiter
  import noc_arb_pkg::*;
#(
  parameter int RADIX_IN   = 2,
  parameter int RADIX_OUT  = 2,
  parameter int FLIT_W     = NOC_FLIT_W,
  parameter int STAGE      = 0,
  parameter int DEST_MSB   = FLIT_W - 4,
  parameter int DOWN_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [RADIX_IN-1:0]                in_empty,
  input  logic [RADIX_IN-1:0][FLIT_W-1:0]    in_data,
  output logic [RADIX_IN-1:0]                in_deq,
  output logic [RADIX_OUT-1:0]               out_enq,
  output logic [RADIX_OUT-1:0][FLIT_W-1:0]   out_data,
  input  logic [RADIX_OUT-1:0]               out_credit_ret
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [RADIX_OUT-1:0][31:0]         stat_grant_cnt,
  output logic [RADIX_OUT-1:0][31:0]         stat_stall_cnt
`endif
);

  localparam int SEL_W    = (RADIX_OUT > 1) ? $clog2(RADIX_OUT) : 1;
  localparam int ROUTE_HI = DEST_MSB - STAGE * SEL_W;
  localparam int CREDIT_W = $clog2(DOWN_DEPTH + 1);

  logic [RADIX_OUT-1:0][RADIX_IN-1:0] req_s;
  logic [RADIX_OUT-1:0][RADIX_IN-1:0] grant_s;
  logic [RADIX_OUT-1:0]               grant_any_s;
  logic [RADIX_OUT-1:0]               arb_en_s;
  logic [RADIX_OUT-1:0]               credit_full_s;
  logic [RADIX_OUT-1:0][FLIT_W-1:0]   win_data_s;
  logic [RADIX_OUT-1:0][CREDIT_W-1:0] credit_r;

  // Decode each head flit's route field into a request for one output.
  always_comb begin
    req_s = '0;
    for (int i = 0; i < RADIX_IN; i++) begin
      for (int o = 0; o < RADIX_OUT; o++) begin
        req_s[o][i] = !in_empty[i] && (in_data[i][ROUTE_HI -: SEL_W] == SEL_W'(o));
      end
    end
  end

  // Eligibility uses only the registered credit, never the same-cycle return.
  always_comb begin
    for (int o = 0; o < RADIX_OUT; o++) begin
      arb_en_s[o]      = !rst && (credit_r[o] != '0);
      credit_full_s[o] = (credit_r[o] == CREDIT_W'(DOWN_DEPTH));
    end
  end

  for (genvar o = 0; o < RADIX_OUT; o++) begin : g_arb
    noc_rr_arb #(
      .N(RADIX_IN)
    ) u_rr_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (req_s[o]),
      .en    (arb_en_s[o]),
      .update(1'b1),
      .grant (grant_s[o])
    );
  end

  // Collapse per-output grants into dequeues and select the winning flit.
  always_comb begin
    in_deq      = '0;
    win_data_s  = '0;
    grant_any_s = '0;
    for (int o = 0; o < RADIX_OUT; o++) begin
      grant_any_s[o] = |grant_s[o];
      for (int i = 0; i < RADIX_IN; i++) begin
        in_deq[i]     = in_deq[i] | grant_s[o][i];
        win_data_s[o] = win_data_s[o] | (in_data[i] & {FLIT_W{grant_s[o][i]}});
      end
    end
  end

  // Registered output stage; data holds between grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_enq  <= '0;
      out_data <= '0;
    end else begin
      for (int o = 0; o < RADIX_OUT; o++) begin
        out_enq[o] <= grant_any_s[o];
        if (grant_any_s[o]) begin
          out_data[o] <= win_data_s[o];
        end else begin
          out_data[o] <= out_data[o];
        end
      end
    end
  end

  // Credits are taken at grant time, covering the flit still in the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < RADIX_OUT; o++) begin
        credit_r[o] <= CREDIT_W'(DOWN_DEPTH);
      end
    end else begin
      for (int o = 0; o < RADIX_OUT; o++) begin
        case ({grant_any_s[o], out_credit_ret[o]})
          2'b10:   credit_r[o] <= credit_r[o] - CREDIT_W'(1);
          2'b01:   credit_r[o] <= credit_full_s[o] ? credit_r[o] : credit_r[o] + CREDIT_W'(1);
          default: credit_r[o] <= credit_r[o];
        endcase
      end
    end
  end

  noc_arb_credit_chk #(
    .R(RADIX_OUT)
  ) u_credit_chk (
    .clk        (clk),
    .rst        (rst),
    .credit_ret (out_credit_ret),
    .credit_full(credit_full_s)
  );

`ifdef NOC_ARB_STATS_EN
  logic [RADIX_OUT-1:0] stall_s;

  // A stall is a cycle with pending requests but no credit.
  always_comb begin
    for (int o = 0; o < RADIX_OUT; o++) begin
      stall_s[o] = (|req_s[o]) && (credit_r[o] == '0);
    end
  end

  // Saturating grant and stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grant_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      for (int o = 0; o < RADIX_OUT; o++) begin
        if (grant_any_s[o] && (stat_grant_cnt[o] != 32'hFFFF_FFFF)) begin
          stat_grant_cnt[o] <= stat_grant_cnt[o] + 32'd1;
        end else begin
          stat_grant_cnt[o] <= stat_grant_cnt[o];
        end
        if (stall_s[o] && (stat_stall_cnt[o] != 32'hFFFF_FFFF)) begin
          stat_stall_cnt[o] <= stat_stall_cnt[o] + 32'd1;
        end else begin
          stat_stall_cnt[o] <= stat_stall_cnt[o];
        end
      end
    end
  end
`endif

endmodule
